// File: rtl/ahb2_sram_slv.sv
// AHB SRAM slave over a 2^P_DEPTH_LOG2 x 32 array; `AHB2_SRAM_SLV_ERRRESP_EN enables ERROR on illegal size/alignment.
// Latency: a legal transfer completes P_WAIT cycles after acceptance; an illegal one with ERROR enabled takes two cycles.
// Backpressure: hreadyo is low during wait and ERR1 cycles; an address phase is taken only while hreadyi is high.
module ahb2_sram_slv #(
   parameter int P_DEPTH_LOG2 = 15,
   parameter int P_WAIT       = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [1:0]  htrans,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [31:0] hwdata,
   input  logic        hreadyi,
   output logic        hreadyo,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata
);

   localparam int         AW        = P_DEPTH_LOG2;
   localparam logic [2:0] WAIT_INIT = (P_WAIT > 0) ? 3'(P_WAIT - 1) : 3'd0;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_ERR  = 2'b01;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ERR1, ST_ERR2} state_t;

   state_t        state_q, state_d;
   logic          act_q, act_d;
   logic          wr_q, wr_d;
   logic [3:0]    be_q, be_d;
   logic [AW-1:0] idx_q, idx_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          hreadyo_q, hreadyo_d;
   logic [1:0]    hresp_q, hresp_d;
   logic [31:0]   hrdata_q, hrdata_d;

   logic [31:0]   mem [0:(2**AW)-1];

   logic          accept;
   logic          a_illegal;
   logic [3:0]    a_be;
   logic [AW-1:0] a_idx;
   logic [AW-1:0] rd_idx;
   logic          wr_now;
   logic [31:0]   wr_word;
   logic [31:0]   rd_word;
   logic          unused_ok;

   assign accept    = hsel & hreadyi & htrans[1];
   assign a_idx     = haddr[AW+1:2];
   assign wr_now    = act_q & wr_q & hreadyo_q;
   assign rd_idx    = (hreadyo_q & accept) ? a_idx : idx_q;
   assign unused_ok = ^{haddr, htrans[0], hburst, hprot};

   // Illegal sizes fall back to a full word; misaligned offsets are masked to the size.
   always_comb begin
      case (hsize)
         3'b000:  a_be = 4'b0001 << haddr[1:0];
         3'b001:  a_be = haddr[1] ? 4'b1100 : 4'b0011;
         default: a_be = 4'b1111;
      endcase
   end

`ifdef AHB2_SRAM_SLV_ERRRESP_EN
   assign a_illegal = (hsize > 3'b010)
                    | ((hsize == 3'b001) & haddr[0])
                    | ((hsize == 3'b010) & (haddr[1:0] != 2'b00));
`else
   assign a_illegal = 1'b0;
`endif

   always_comb begin
      wr_word = mem[idx_q];
      for (int i = 0; i < 4; i++) begin
         if (be_q[i]) wr_word[8*i +: 8] = hwdata[8*i +: 8];
      end
   end

   // A read taken on the same edge a write completes must see the merged word.
   assign rd_word = (wr_now && (rd_idx == idx_q)) ? wr_word : mem[rd_idx];

   always_comb begin
      state_d   = state_q;
      act_d     = act_q;
      wr_d      = wr_q;
      be_d      = be_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      hreadyo_d = hreadyo_q;
      hresp_d   = hresp_q;
      hrdata_d  = hrdata_q;

      case (state_q)
         ST_WAIT: begin
            if (!hreadyo_q) begin
               if (cnt_q == 3'd0) begin
                  hreadyo_d = 1'b1;
                  if (!wr_q) hrdata_d = rd_word;
               end else begin
                  cnt_d = cnt_q - 3'd1;
               end
            end
         end
         ST_ERR1: begin
            state_d   = ST_ERR2;
            hreadyo_d = 1'b1;
         end
         default: ;
      endcase

      // Any cycle with hreadyo high retires the current data phase and may open the next.
      if (hreadyo_q) begin
         if (accept) begin
            idx_d = a_idx;
            wr_d  = hwrite;
            be_d  = a_be;
            if (a_illegal) begin
               state_d   = ST_ERR1;
               act_d     = 1'b0;
               hreadyo_d = 1'b0;
               hresp_d   = RESP_ERR;
            end else begin
               act_d   = 1'b1;
               hresp_d = RESP_OKAY;
               if (P_WAIT == 0) begin
                  state_d   = ST_IDLE;
                  hreadyo_d = 1'b1;
                  if (!hwrite) hrdata_d = rd_word;
               end else begin
                  state_d   = ST_WAIT;
                  cnt_d     = WAIT_INIT;
                  hreadyo_d = 1'b0;
               end
            end
         end else begin
            state_d   = ST_IDLE;
            act_d     = 1'b0;
            hreadyo_d = 1'b1;
            hresp_d   = RESP_OKAY;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         act_q     <= 1'b0;
         wr_q      <= 1'b0;
         be_q      <= 4'b0000;
         idx_q     <= '0;
         cnt_q     <= 3'd0;
         hreadyo_q <= 1'b1;
         hresp_q   <= RESP_OKAY;
         hrdata_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         act_q     <= act_d;
         wr_q      <= wr_d;
         be_q      <= be_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         hreadyo_q <= hreadyo_d;
         hresp_q   <= hresp_d;
         hrdata_q  <= hrdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_now) mem[idx_q] <= wr_word;
   end

   assign hreadyo = hreadyo_q;
   assign hresp   = hresp_q;
   assign hrdata  = hrdata_q;

endmodule

// File: tb/tb_ahb2_sram_slv.sv
// Bench for ahb2_sram_slv: instance 0 with no wait states, instance 1 with three, checked against a byte-level memory model.
module tb_ahb2_sram_slv;

   localparam int MEMB = 1 << 17;
`ifdef AHB2_SRAM_SLV_ERRRESP_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   typedef struct {
      int          waits;
      logic [1:0]  r0;
      logic [1:0]  rf;
      logic [31:0] rd;
   } exp_t;

   logic        clk, rst_n;
   logic        hsel    [2];
   logic [31:0] haddr   [2];
   logic [1:0]  htrans  [2];
   logic        hwrite  [2];
   logic [2:0]  hsize   [2];
   logic [2:0]  hburst  [2];
   logic [3:0]  hprot   [2];
   logic [31:0] hwdata  [2];
   logic        hreadyi [2];
   logic        hreadyo [2];
   logic [1:0]  hresp   [2];
   logic [31:0] hrdata  [2];
   bit          drv_on  [2];

   int          tests, fails;
   exp_t        q0[$], q1[$];
   logic [7:0]  mdl [int];
   logic [31:0] last_rd [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      assign hreadyi[g] = hreadyo[g];
      ahb2_sram_slv #(.P_DEPTH_LOG2(15), .P_WAIT(g == 0 ? 0 : 3)) u_dut (
         .clk(clk), .rst_n(rst_n), .hsel(hsel[g]), .haddr(haddr[g]), .htrans(htrans[g]),
         .hwrite(hwrite[g]), .hsize(hsize[g]), .hburst(hburst[g]), .hprot(hprot[g]),
         .hwdata(hwdata[g]), .hreadyi(hreadyi[g]), .hreadyo(hreadyo[g]), .hresp(hresp[g]),
         .hrdata(hrdata[g]));
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic int key(input int k, input logic [31:0] a);
      return k * MEMB + int'(a % 32'(MEMB));
   endfunction

   // Reference: an accepted legal transfer touches the bytes it names; reads return the word they fall in.
   function automatic void expect_beat(input int k, input bit acc, input bit wr, input logic [2:0] sz,
                                       input logic [31:0] a, input logic [31:0] wd);
      exp_t        e;
      int          nb, ln;
      logic [31:0] base, w;
      bit          bad;
      e.waits = 0; e.r0 = 2'b00; e.rf = 2'b00;
      if (acc) begin
         bad = (sz > 3'd2) || ((a % (32'd1 << sz)) != 0);
         if (bad && ERR_EN) begin
            e.waits = 1; e.r0 = 2'b01; e.rf = 2'b01;
         end else begin
            nb      = (sz >= 3'd2) ? 4 : (1 << sz);
            base    = a - (a % 32'(nb));
            e.waits = (k == 0) ? 0 : 3;
            if (wr) begin
               for (int i = 0; i < nb; i++) begin
                  ln = int'((base + 32'(i)) % 32'd4);
                  mdl[key(k, base + 32'(i))] = wd[8*ln +: 8];
               end
            end else begin
               w = 32'd0;
               for (int i = 0; i < 4; i++) w[8*i +: 8] = mdl[key(k, a - (a % 32'd4) + 32'(i))];
               last_rd[k] = w;
            end
         end
      end
      e.rd = last_rd[k];
      if (k == 0) q0.push_back(e); else q1.push_back(e);
   endfunction

   // Call between a rising edge and the next falling edge.
   task automatic beat(input int k, input bit sel, input logic [1:0] tr, input bit wr,
                       input logic [2:0] sz, input logic [31:0] a, input logic [31:0] wd);
      bit r;
      int n;
      hsel[k] = sel; htrans[k] = tr; hwrite[k] = wr; hsize[k] = sz; haddr[k] = a;
      hburst[k] = 3'($urandom); hprot[k] = 4'($urandom);
      drv_on[k] = 1'b1;
      expect_beat(k, sel & tr[1], wr, sz, a, wd);
      n = 0;
      forever begin
         @(negedge clk);
         r = hreadyo[k];
         @(posedge clk);
         if (r) break;
         n++;
         if (n > 40) begin
            tests++; fails++;
            $display("FAIL k%0d beat_timeout: got no hreadyo, expected within 40 cycles", k);
            break;
         end
      end
      #1;
      drv_on[k] = 1'b0; hsel[k] = 1'b0; htrans[k] = 2'b00;
      hwdata[k] = wd;
   endtask

   task automatic flush(input int k);
      repeat (3) beat(k, 1'b0, 2'b00, 1'b0, 3'b000, 32'd0, $urandom);
   endtask

   task automatic mon(input int k);
      bit         pend, first, hr, act;
      int         w;
      logic [1:0] r0;
      exp_t       e;
      pend = 0; first = 0; w = 0; r0 = 2'b00;
      forever begin
         @(negedge clk);
         if (!rst_n) pend = 0;
         if (pend) begin
            if (first) begin r0 = hresp[k]; first = 0; end
            if (!hreadyo[k]) w++;
            else begin
               pend = 0;
               if ((k == 0 ? q0.size() : q1.size()) == 0) begin
                  tests++; fails++;
                  $display("FAIL k%0d unexpected_completion: got a data phase, expected none", k);
               end else begin
                  if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
                  chk($sformatf("k%0d waits", k), 32'(w), 32'(e.waits));
                  chk($sformatf("k%0d hresp_first", k), 32'(r0), 32'(e.r0));
                  chk($sformatf("k%0d hresp_final", k), 32'(hresp[k]), 32'(e.rf));
                  chk($sformatf("k%0d hrdata", k), hrdata[k], e.rd);
               end
            end
         end
         hr  = hreadyo[k];
         act = drv_on[k] & rst_n;
         @(posedge clk);
         if (hr && act) begin pend = 1; w = 0; first = 1; end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no finish, expected finish before 1 ms");
      $fatal(1, "watchdog");
   end

   initial fork mon(0); mon(1); join_none

   initial begin
      logic [2:0]  sz;
      logic [31:0] a;
      logic [1:0]  tr;
      tests = 0; fails = 0;
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         hsel[k] = 0; haddr[k] = 0; htrans[k] = 0; hwrite[k] = 0; hsize[k] = 0;
         hburst[k] = 0; hprot[k] = 0; hwdata[k] = 0; drv_on[k] = 0; last_rd[k] = 0;
      end
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("k%0d rst_hreadyo", k), 32'(hreadyo[k]), 32'd1);
         chk($sformatf("k%0d rst_hresp", k), 32'(hresp[k]), 32'd0);
         chk($sformatf("k%0d rst_hrdata", k), hrdata[k], 32'd0);
      end
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;

      // Back-to-back write then read of the same word with no wait states.
      beat(0, 1, 2'b10, 1, 3'b010, 32'h100, 32'hDEADBEEF);
      beat(0, 1, 2'b10, 0, 3'b010, 32'h100, $urandom);
      flush(0);

      // Three wait states on a single read.
      beat(1, 1, 2'b10, 1, 3'b010, 32'h0, 32'h0BADF00D);
      flush(1);
      beat(1, 1, 2'b10, 0, 3'b010, 32'h0, $urandom);
      flush(1);

      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++)
            beat(k, 1, 2'b10, 1, 3'b010, 32'h100 + 32'(4*i), $urandom);
         beat(k, 1, 2'b10, 1, 3'b010, 32'h300, 32'h01020304);
         beat(k, 1, 2'b10, 1, 3'b010, 32'h40, 32'h12345678);
         beat(k, 1, 2'b10, 1, 3'b010, 32'h0, 32'hA0A00000 | 32'(k));
         beat(k, 1, 2'b10, 1, 3'b010, 32'h4, 32'hB0B00000 | 32'(k));
         beat(k, 1, 2'b10, 1, 3'b010, 32'h1FFF8, 32'hC0C00000 | 32'(k));
         beat(k, 1, 2'b10, 1, 3'b010, 32'h1FFFC, 32'hD0D00000 | 32'(k));

         // Little-endian byte and halfword lanes.
         beat(k, 1, 2'b10, 1, 3'b000, 32'h200, 32'h00000011);
         beat(k, 1, 2'b10, 1, 3'b000, 32'h201, 32'h00002200);
         beat(k, 1, 2'b10, 1, 3'b000, 32'h202, 32'h00330000);
         beat(k, 1, 2'b10, 1, 3'b000, 32'h203, 32'h44000000);
         beat(k, 1, 2'b10, 0, 3'b010, 32'h200, $urandom);
         beat(k, 1, 2'b10, 1, 3'b001, 32'h202, 32'hABCD0000);
         beat(k, 1, 2'b10, 0, 3'b010, 32'h200, $urandom);

         // Misaligned halfword: ERROR when enabled, otherwise masked onto 0x300.
         beat(k, 1, 2'b10, 1, 3'b001, 32'h301, 32'h5566BEEF);
         beat(k, 1, 2'b10, 0, 3'b010, 32'h300, $urandom);

         // INCR4 read burst crossing the top of the array, with a BUSY beat inside.
         beat(k, 1, 2'b10, 0, 3'b010, 32'h1FFF8, $urandom);
         beat(k, 1, 2'b11, 0, 3'b010, 32'h1FFFC, $urandom);
         beat(k, 1, 2'b01, 0, 3'b010, 32'h20000, $urandom);
         beat(k, 1, 2'b11, 0, 3'b010, 32'h20000, $urandom);
         beat(k, 1, 2'b11, 0, 3'b010, 32'h20004, $urandom);
         flush(k);

         for (int n = 0; n < 150; n++) begin
            sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            a  = ($urandom << 17) | (32'h100 + 32'($urandom_range(0, 63)));
            tr = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            beat(k, $urandom_range(0, 7) != 0, tr, 1'($urandom_range(0, 1)), sz, a, $urandom);
         end
         flush(k);
      end

      // Reset in the second wait cycle of a write aborts the write.
      hsel[1] = 1; htrans[1] = 2'b10; hwrite[1] = 1; hsize[1] = 3'b010; haddr[1] = 32'h40;
      @(posedge clk); #1;
      hsel[1] = 0; htrans[1] = 2'b00; hwdata[1] = 32'hCAFEF00D;
      @(posedge clk); #2;
      chk("k1 pre_rst_hreadyo", 32'(hreadyo[1]), 32'd0);
      rst_n = 1'b0;
      #1;
      chk("k1 rst_mid_hreadyo", 32'(hreadyo[1]), 32'd1);
      chk("k1 rst_mid_hresp", 32'(hresp[1]), 32'd0);
      chk("k1 rst_mid_hrdata", hrdata[1], 32'd0);
      last_rd[0] = 32'd0; last_rd[1] = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      beat(1, 1, 2'b10, 0, 3'b010, 32'h40, $urandom);
      beat(0, 1, 2'b10, 0, 3'b010, 32'h40, $urandom);
      flush(1);
      flush(0);

      for (int i = 0; i < 20 && (q0.size() + q1.size()) != 0; i++) @(posedge clk);
      chk("pending_expectations", 32'(q0.size() + q1.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/ahb2_sram_slv.md
AHB2_SRAM_SLV -- requirements
Module: ahb2_sram_slv

Interface
REQ-001 Parameter P_DEPTH_LOG2, default 15, sets the array to 2^P_DEPTH_LOG2 32-bit words (128 KB at default).
REQ-002 Parameter P_WAIT, default 0, sets wait states (0..7) inserted before each accepted transfer completes.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 hsel  input  1  slave select from the bus decoder.
REQ-006 haddr  input  32  byte address; only haddr[P_DEPTH_LOG2+1:0] is decoded.
REQ-007 htrans  input  2  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
REQ-008 hwrite  input  1  1=write, 0=read.
REQ-009 hsize  input  3  000=byte, 001=halfword, 010=word; larger values are illegal.
REQ-010 hburst  input  3  burst type; accepted and ignored.
REQ-011 hprot  input  4  protection; accepted and ignored.
REQ-012 hwdata  input  32  write data, valid in the data phase.
REQ-013 hreadyi  input  1  bus HREADY; the address phase is sampled only when it is high.
REQ-014 hreadyo  output  1  slave ready; low extends the data phase.
REQ-015 hresp  output  2  00=OKAY, 01=ERROR.
REQ-016 hrdata  output  32  read data, valid when hreadyo=1 in a read data phase.

Function
REQ-017 A transfer is accepted when hsel & hreadyi & htrans[1]; at acceptance the block latches haddr, hwrite and hsize.
REQ-018 IDLE/BUSY, or hsel=0 with hreadyi=1, gives a zero-wait OKAY data phase with no array access.
REQ-019 FSM states: IDLE, WAIT, ERR1, ERR2.
REQ-020 IDLE: a legal accepted transfer moves to WAIT if P_WAIT>0; if P_WAIT=0 it completes in the next cycle with hreadyo=1.
REQ-021 WAIT: hreadyo=0 for exactly P_WAIT cycles, then one cycle with hreadyo=1, hresp=OKAY. A new transfer may be accepted in that completing cycle (pipelined back-to-back).
REQ-022 Write: byte lanes are selected by the latched hsize and haddr[1:0], little-endian. hwdata is sampled and written at the completing data-phase edge (hreadyo=1).
REQ-023 Read: hrdata carries the full addressed word and reflects every write completed on an earlier edge, including a write to the same address in the immediately preceding transfer.
REQ-024 hrdata holds its last value outside read completion cycles.
REQ-025 Address bits above P_DEPTH_LOG2+1 are ignored, so the address space wraps modulo the array size.

Reset
REQ-026 While rst_n=0: FSM=IDLE, hreadyo=1, hresp=00, hrdata=0, and all latched address-phase state is cleared. Array contents are not reset.
REQ-027 Reset asserted mid-transfer aborts it; a pending write is not performed.
REQ-028 After deassertion the first acceptance occurs no earlier than the first rising edge with rst_n=1.

Configuration
REQ-029 Macro AHB2_SRAM_SLV_ERRRESP_EN, when defined, enables the ERROR response for illegal transfers: hsize>010, or haddr not aligned to hsize.
REQ-030 With the macro defined, an illegal accepted transfer follows IDLE→ERR1 (hreadyo=0, hresp=01) → ERR2 (hreadyo=1, hresp=01) → IDLE. It ignores P_WAIT, does not write the array, and leaves hrdata unchanged.
REQ-031 With the macro defined, an accepted transfer seen during ERR2 (master not cancelling) is processed normally.
REQ-032 Without the macro, illegal transfers complete as OKAY after P_WAIT. Illegal hsize is treated as word, and misaligned low address bits are masked to the hsize alignment.

Verification
REQ-033 P_WAIT=0: word write 0xDEADBEEF @0x100, then read @0x100 back-to-back -> both OKAY, no hreadyo low, hrdata=0xDEADBEEF.
REQ-034 P_WAIT=3: single read @0x0 -> hreadyo low for exactly 3 cycles, then high with OKAY and correct data.
REQ-035 Byte writes 0x11,0x22,0x33,0x44 @0x200..0x203, then word read @0x200 -> 0x44332211; halfword write 0xABCD @0x202 -> word read 0xABCD2211.
REQ-036 Macro defined: halfword write @0x301 -> ERR1/ERR2 two-cycle ERROR and memory unchanged; macro undefined -> OKAY, write lands at 0x300.
REQ-037 Assert rst_n=0 during the 2nd wait cycle of a write with P_WAIT=3 -> hreadyo=1, hresp=00, hrdata=0 immediately, and a read of that address returns the old value.
REQ-038 INCR4 burst of SEQ reads @0x1FFF8 with P_DEPTH_LOG2=15 -> third beat wraps to array word 0; BUSY beats inserted mid-burst get zero-wait OKAY.
